prog_timer: RTL and testbench

Programmable interval timer for the PWM system. Generalised successor of the basic terminal-count timer: runtime-selectable periodic or one-shot mode, programmable clock prescaler, explicit start/stop/pause control, and shadowed terminal value so reprogramming never corrupts a running period. Drives the period/duty tick for downstream PWM channels and can also act as a software timeout.

---
 rtl/prog_timer_pkg.sv | 12 +
 rtl/timer_prescaler.sv | 33 +++
 rtl/prog_timer.sv | 97 +++++++++
 tb/tb_prog_timer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the programmable interval timer.
package prog_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: while enabled, emits a one-cycle tick every setting_i+1 cycles.
module timer_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [PRE_W-1:0] setting_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pcnt_q, pcnt_d;

  // >= rather than == so a setting that shrinks below the current count still wraps.
  assign tick_o = en_i && !clr_i && (pcnt_q >= setting_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      if (tick_o) pcnt_d = '0;
      else        pcnt_d = pcnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable interval timer: periodic or one-shot, prescaled, with pause and
// shadowed terminal/prescale values that only change at start or period wrap.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] final_value,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] f_sh_q, f_sh_d;
  logic [PRE_W-1:0] p_sh_q, p_sh_d;
  logic             mode_sh_q, mode_sh_d;
  logic             done_q, done_d;
  logic             pre_en, pre_clr, tick;

  // Control commands override counting, so the prescaler must not advance on them.
  assign pre_clr = stop || start;
  assign pre_en  = (state_q == RUN) && !pause && !pre_clr;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en_i      (pre_en),
    .clr_i     (pre_clr),
    .setting_i (p_sh_q),
    .tick_o    (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    f_sh_d    = f_sh_q;
    p_sh_d    = p_sh_q;
    mode_sh_d = mode_sh_q;
    done_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      state_d   = RUN;
      count_d   = '0;
      f_sh_d    = final_value;
      p_sh_d    = prescale;
      mode_sh_d = mode;
    end else if (tick) begin
      if (count_q < f_sh_q) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = '0;
        done_d  = 1'b1;
        if (mode_sh_q == MODE_ONESHOT) begin
          state_d = IDLE;
        end else begin
          f_sh_d = final_value;
          p_sh_d = prescale;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      f_sh_q    <= '0;
      p_sh_q    <= '0;
      mode_sh_q <= MODE_PERIODIC;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      f_sh_q    <= f_sh_d;
      p_sh_q    <= p_sh_d;
      mode_sh_q <= mode_sh_d;
      done_q    <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios plus randomized traffic,
// all compared against an elapsed-cycle reference model.
module tb_prog_timer;
  import prog_timer_pkg::*;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, stop, pause, mode;
  logic [WIDTH-1:0] final_value;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             done, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a run is a number of unpaused cycles since the period began;
  // the period lasts (F+1)(P+1) cycles and count is elapsed/(P+1).
  bit m_run, m_done, m_mode;
  int m_f, m_p, m_el;

  prog_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .mode        (mode),
    .final_value (final_value),
    .prescale    (prescale),
    .count       (count),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_mode = 0; m_f = 0; m_p = 0; m_el = 0;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge,
  // then settle to a safe sampling point.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_done = 0;
      if (stop) begin
        m_run = 0; m_el = 0;
      end else if (start) begin
        m_run = 1; m_el = 0;
        m_f = int'(final_value); m_p = int'(prescale); m_mode = mode;
      end else if (m_run && !pause) begin
        m_el++;
        if (m_el == (m_f + 1) * (m_p + 1)) begin
          m_el = 0; m_done = 1;
          if (m_mode == MODE_ONESHOT) m_run = 0;
          else begin m_f = int'(final_value); m_p = int'(prescale); end
        end
      end
    end
    #1;
  endtask

  function automatic logic [WIDTH+1:0] exp_obs();
    int c;
    c = m_run ? (m_el / (m_p + 1)) : 0;
    return {c[WIDTH-1:0], m_done, m_run};
  endfunction

  task automatic drive_idle();
    start = 0; stop = 0; pause = 0; mode = MODE_PERIODIC;
    final_value = '0; prescale = '0;
  endtask

  task automatic drive_start(input int f, input int p, input logic md);
    final_value = WIDTH'(f); prescale = PRE_W'(p); mode = md;
    start = 1; cyc(); start = 0;
  endtask

  task automatic drive_stop();
    stop = 1; cyc(); stop = 0;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    cyc(); cyc();
    n_cmp++;
    if ({count, done, busy} !== {WIDTH'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: count/done/busy got %0d/%b/%b want 0/0/0", count, done, busy);
    end
    rst = 0;
    cyc();
    n_cmp++;
    if ({count, done, busy} !== exp_obs()) begin
      n_err++;
      $display("FAIL reset_release: got %0d/%b/%b want idle", count, done, busy);
    end
  endtask

  task automatic test_periodic();
    logic [15:0] exp_q[$];
    logic [15:0] hits[$];
    exp_q = '{16'd4, 16'd8, 16'd12};
    drive_start(3, 0, MODE_PERIODIC);
    n_cmp++;
    if ({count, done, busy} !== {WIDTH'(0), 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL periodic_start: count/done/busy got %0d/%b/%b want 0/0/1", count, done, busy);
    end
    for (int e = 1; e <= 13; e++) begin
      cyc();
      if (done) hits.push_back(16'(e));
      n_cmp++;
      if ({count, done, busy} !== exp_obs()) begin
        n_err++;
        $display("FAIL periodic_cycle e=%0d: got %h want %h", e, {count, done, busy}, exp_obs());
      end
    end
    n_cmp++;
    if (hits.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL periodic_done_count: got %0d pulses want %0d", hits.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (hits[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL periodic_done_edge: got %0d want %0d", hits[i], exp_q[i]);
        end
      end
    end
    drive_stop();
  endtask

  task automatic test_oneshot();
    logic [15:0] hits[$];
    drive_start(2, 2, MODE_ONESHOT);
    mode = MODE_PERIODIC;
    for (int e = 1; e <= 14; e++) begin
      cyc();
      if (done) hits.push_back(16'(e));
      n_cmp++;
      if ({count, done, busy} !== exp_obs()) begin
        n_err++;
        $display("FAIL oneshot_cycle e=%0d: got %h want %h", e, {count, done, busy}, exp_obs());
      end
      if (e == 9) begin
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
          n_err++;
          $display("FAIL oneshot_end: done/busy got %b/%b want 1/0", done, busy);
        end
      end
    end
    n_cmp++;
    if (hits.size() != 1 || hits[0] !== 16'd9) begin
      n_err++;
      $display("FAIL oneshot_single: got %0d pulses first=%0d want 1 at 9", hits.size(),
               hits.size() > 0 ? hits[0] : 16'd0);
    end
  endtask

  task automatic test_reprogram();
    logic [15:0] exp_q[$];
    logic [15:0] hits[$];
    exp_q = '{16'd5, 16'd7, 16'd9};
    drive_start(4, 0, MODE_PERIODIC);
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) final_value = WIDTH'(1);
      cyc();
      if (done) hits.push_back(16'(e));
      n_cmp++;
      if ({count, done, busy} !== exp_obs()) begin
        n_err++;
        $display("FAIL reprogram_cycle e=%0d: got %h want %h", e, {count, done, busy}, exp_obs());
      end
    end
    n_cmp++;
    if (hits.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL reprogram_done_count: got %0d pulses want %0d", hits.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (hits[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL reprogram_done_edge: got %0d want %0d", hits[i], exp_q[i]);
        end
      end
    end
    drive_stop();
  endtask

  task automatic test_pause();
    logic [15:0] hits[$];
    drive_start(3, 1, MODE_PERIODIC);
    for (int e = 1; e <= 12; e++) begin
      pause = (e >= 3 && e <= 5);
      cyc();
      if (done) hits.push_back(16'(e));
      n_cmp++;
      if ({count, done, busy} !== exp_obs()) begin
        n_err++;
        $display("FAIL pause_cycle e=%0d: got %h want %h", e, {count, done, busy}, exp_obs());
      end
    end
    pause = 0;
    n_cmp++;
    if (hits.size() != 1 || hits[0] !== 16'd11) begin
      n_err++;
      $display("FAIL pause_done_edge: got %0d pulses first=%0d want 1 at 11", hits.size(),
               hits.size() > 0 ? hits[0] : 16'd0);
    end
    drive_stop();
  endtask

  task automatic test_stop_start();
    drive_start(5, 0, MODE_PERIODIC);
    cyc(); cyc();
    start = 1; stop = 1;
    cyc();
    start = 0; stop = 0;
    n_cmp++;
    if ({count, done, busy} !== {WIDTH'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL stop_beats_start: count/done/busy got %0d/%b/%b want 0/0/0", count, done, busy);
    end
    // stop landing exactly on the wrap edge
    drive_start(2, 0, MODE_PERIODIC);
    cyc(); cyc();
    stop = 1; cyc(); stop = 0;
    n_cmp++;
    if ({count, done, busy} !== {WIDTH'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL stop_on_wrap: count/done/busy got %0d/%b/%b want 0/0/0", count, done, busy);
    end
    // restart landing exactly on the wrap edge
    drive_start(2, 0, MODE_PERIODIC);
    cyc(); cyc();
    start = 1; cyc(); start = 0;
    n_cmp++;
    if ({count, done, busy} !== {WIDTH'(0), 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL restart_on_wrap: count/done/busy got %0d/%b/%b want 0/0/1", count, done, busy);
    end
    cyc();
    n_cmp++;
    if ({count, done, busy} !== exp_obs()) begin
      n_err++;
      $display("FAIL restart_resume: got %h want %h", {count, done, busy}, exp_obs());
    end
    drive_stop();
  endtask

  task automatic test_async_reset();
    drive_start(9, 0, MODE_PERIODIC);
    for (int e = 1; e <= 5; e++) cyc();
    n_cmp++;
    if (count !== WIDTH'(5)) begin
      n_err++;
      $display("FAIL async_reset_pre: count got %0d want 5", count);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({count, done, busy} !== {WIDTH'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_now: count/done/busy got %0d/%b/%b want 0/0/0", count, done, busy);
    end
    cyc();
    rst = 0;
  endtask

  task automatic test_max_final();
    logic [15:0] hits[$];
    drive_start(255, 0, MODE_PERIODIC);
    final_value = WIDTH'(255);
    for (int e = 1; e <= 520; e++) begin
      cyc();
      if (done) hits.push_back(16'(e));
      n_cmp++;
      if ({count, done, busy} !== exp_obs()) begin
        n_err++;
        $display("FAIL max_final_cycle e=%0d: got %h want %h", e, {count, done, busy}, exp_obs());
      end
    end
    n_cmp++;
    if (hits.size() != 2 || hits[0] !== 16'd256 || hits[1] !== 16'd512) begin
      n_err++;
      $display("FAIL max_final_done: got %0d pulses first=%0d want 2 at 256,512", hits.size(),
               hits.size() > 0 ? hits[0] : 16'd0);
    end
    drive_stop();
  endtask

  task automatic test_random();
    for (int e = 0; e < 4000; e++) begin
      start       = ($urandom_range(0, 99) < 4);
      stop        = ($urandom_range(0, 99) < 2);
      pause       = ($urandom_range(0, 99) < 20);
      mode        = 1'($urandom_range(0, 1));
      final_value = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 40))
                                                : WIDTH'($urandom_range(0, 6));
      prescale    = PRE_W'($urandom_range(0, 3));
      cyc();
      n_cmp++;
      if ({count, done, busy} !== exp_obs()) begin
        n_err++;
        $display("FAIL random_cycle e=%0d: got %h want %h", e, {count, done, busy}, exp_obs());
      end
    end
    drive_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_oneshot();
    test_reprogram();
    test_pause();
    test_stop_start();
    test_async_reset();
    test_max_final();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
